// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   state_e   : arbiter FSM states (IDLE, BUSY, DONE)
//   OWN_*     : encoding of the debug owner output
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IF   = 2'd1;
   localparam logic [1:0] OWN_LS   = 2'd2;

endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt: counts cycles spent waiting for the memory and flags
// when TIMEOUT cycles have elapsed.
//   clk, reset : clock, synchronous active-high reset
//   clear      : forces the count back to zero
//   enable     : advances the count by one per cycle
//   expired    : high while the count equals TIMEOUT-1 (count holds there)
module arb_timeout_cnt #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (read
// only) and the load/store unit. Load/store wins ties, except that after
// MAX_LS_STREAK consecutive load/store grants taken while fetch was waiting,
// fetch is granted once. One transaction at a time: IDLE -> BUSY -> DONE.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   if_req/if_addr               fetch request (level) and address
//   if_ack/if_rdata/if_err       fetch completion pulse, data, timeout flag
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_be               load/store request and fields
//   ls_ack/ls_rdata/ls_err       load/store completion pulse, data, timeout flag
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be             registered memory transaction
//   mem_rdata/mem_ack            memory read data and completion
//   owner                        0 none, 1 fetch, 2 load/store (debug)
//
// Build option: define ARB_TIMEOUT_EN to abort a BUSY phase after TIMEOUT
// cycles without mem_ack (ack returned with err=1, rdata=0). Without it BUSY
// waits forever and the err outputs are constant 0.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW            = 32,
   parameter int unsigned DW            = 32,
   parameter int unsigned MAX_LS_STREAK = 4,
   parameter int unsigned TIMEOUT       = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [AW-1:0]     if_addr,
   output logic              if_ack,
   output logic [DW-1:0]     if_rdata,
   output logic              if_err,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [AW-1:0]     ls_addr,
   input  logic [DW-1:0]     ls_wdata,
   input  logic [DW/8-1:0]   ls_be,
   output logic              ls_ack,
   output logic [DW-1:0]     ls_rdata,
   output logic              ls_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   output logic [DW/8-1:0]   mem_be,
   input  logic [DW-1:0]     mem_rdata,
   input  logic              mem_ack,
   output logic [1:0]        owner
);

   localparam int unsigned SW = $clog2(MAX_LS_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

   state_e            state_q, state_d;
   logic [SW-1:0]     streak_q, streak_d;
   logic [1:0]        owner_q, owner_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [AW-1:0]     mem_addr_q, mem_addr_d;
   logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
   logic [DW/8-1:0]   mem_be_q, mem_be_d;
   logic              if_ack_q, if_ack_d;
   logic              ls_ack_q, ls_ack_d;
   logic [DW-1:0]     if_rdata_q, if_rdata_d;
   logic [DW-1:0]     ls_rdata_q, ls_rdata_d;
   logic              timeout_hit;
   logic              grant_ls;
   logic [DW-1:0]     rdata_v;

   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      owner_d     = owner_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      if_ack_d    = 1'b0;
      ls_ack_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      grant_ls    = 1'b0;
      rdata_v     = '0;
      unique case (state_q)
         IDLE: begin
            if (if_req || ls_req) begin
               // Fetch only wins a tie once load/store has had its full streak.
               grant_ls  = ls_req && (!if_req || (streak_q != STREAK_MAX));
               state_d   = BUSY;
               mem_req_d = 1'b1;
               if (grant_ls) begin
                  owner_d     = OWN_LS;
                  mem_we_d    = ls_we;
                  mem_addr_d  = ls_addr;
                  mem_wdata_d = ls_wdata;
                  mem_be_d    = ls_be;
                  if (!if_req) begin
                     streak_d = '0;
                  end else if (streak_q != STREAK_MAX) begin
                     streak_d = streak_q + 1'b1;
                  end
               end else begin
                  owner_d     = OWN_IF;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
                  mem_be_d    = '1;
                  streak_d    = '0;
               end
            end
         end
         BUSY: begin
            if (mem_ack || timeout_hit) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
               // Stores and aborted transactions return zero data.
               if (mem_ack && !mem_we_q) begin
                  rdata_v = mem_rdata;
               end
               if (owner_q == OWN_IF) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = rdata_v;
               end else begin
                  ls_ack_d   = 1'b1;
                  ls_rdata_d = rdata_v;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            owner_d = OWN_NONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         streak_q    <= '0;
         owner_q     <= OWN_NONE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         if_ack_q    <= 1'b0;
         ls_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         owner_q     <= owner_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         if_ack_q    <= if_ack_d;
         ls_ack_q    <= ls_ack_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   logic expired;
   logic if_err_q, if_err_d;
   logic ls_err_q, ls_err_d;

   // Counter sits at zero outside BUSY, so it restarts on every BUSY entry.
   arb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_q != BUSY),
      .enable  (state_q == BUSY),
      .expired (expired)
   );

   assign timeout_hit = (state_q == BUSY) && expired;

   always_comb begin
      if_err_d = 1'b0;
      ls_err_d = 1'b0;
      // An ack arriving on the final cycle still counts as a normal completion.
      if (timeout_hit && !mem_ack) begin
         if (owner_q == OWN_IF) begin
            if_err_d = 1'b1;
         end else begin
            ls_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if_err_q <= 1'b0;
         ls_err_q <= 1'b0;
      end else begin
         if_err_q <= if_err_d;
         ls_err_q <= ls_err_d;
      end
   end

   assign if_err = if_err_q;
   assign ls_err = ls_err_q;
`else
   assign timeout_hit = 1'b0;
   assign if_err      = 1'b0;
   assign ls_err      = 1'b0;
`endif

   assign if_ack    = if_ack_q;
   assign if_rdata  = if_rdata_q;
   assign ls_ack    = ls_ack_q;
   assign ls_rdata  = ls_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign owner     = owner_q;

endmodule
